// File: rtl/exc_seq.sv
// Multi-channel exception sequencer: latches IRQ edges, prioritises them against
// invalid-opcode traps, and pulses exc_take. Optional take counter under EXC_SEQ_CNT_EN.
module exc_seq #(
    parameter int N_IRQ     = 4,
    parameter int ESTATUS_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 not_an_instr,
    input  logic                 eret,
    input  logic                 irq_en,
    input  logic [N_IRQ-1:0]     irq_req,
    output logic                 exc_take,
    output logic [ESTATUS_W-1:0] estatus,
    output logic [N_IRQ-1:0]     irq_ack,
    output logic [N_IRQ-1:0]     irq_pending,
    output logic                 in_handler,
    output logic                 fault
`ifdef EXC_SEQ_CNT_EN
    ,
    output logic [15:0]          exc_count
`endif
);

    typedef enum logic [1:0] {RUN, TAKE, HANDLER, FAULT} state_t;

    localparam logic [ESTATUS_W-1:0] CODE_NONE  = ESTATUS_W'(0);
    localparam logic [ESTATUS_W-1:0] CODE_INV   = ESTATUS_W'(2);
    localparam logic [ESTATUS_W-1:0] CODE_FAULT = ESTATUS_W'(15);

    state_t               state, state_nxt;
    logic [N_IRQ-1:0]     irq_prev;
    logic [N_IRQ-1:0]     pending;
    logic [ESTATUS_W-1:0] code, code_nxt;
    logic [N_IRQ-1:0]     ack_sel, ack_sel_nxt;
    logic [N_IRQ-1:0]     irq_low;
    logic [ESTATUS_W-1:0] irq_code;

    // Lowest-index pending bit wins: scan downward so lower indices overwrite.
    always_comb begin
        irq_low  = '0;
        irq_code = CODE_NONE;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (pending[i]) begin
                irq_low     = '0;
                irq_low[i]  = 1'b1;
                irq_code    = ESTATUS_W'(8 + i);
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt   = state;
        code_nxt    = code;
        ack_sel_nxt = ack_sel;
        unique case (state)
            RUN: begin
                if (not_an_instr) begin
                    state_nxt   = TAKE;
                    code_nxt    = CODE_INV;
                    ack_sel_nxt = '0;
                end else if (irq_en && (pending != '0)) begin
                    state_nxt   = TAKE;
                    code_nxt    = irq_code;
                    ack_sel_nxt = irq_low;
                end
            end
            TAKE:    state_nxt = HANDLER;
            HANDLER: begin
                if (not_an_instr) begin
                    state_nxt = FAULT;
                end else if (eret) begin
                    state_nxt = RUN;
                end
            end
            FAULT:   state_nxt = FAULT;
            default: state_nxt = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= RUN;
            irq_prev <= '0;
            pending  <= '0;
            code     <= CODE_NONE;
            ack_sel  <= '0;
        end else begin
            state    <= state_nxt;
            irq_prev <= irq_req;
            code     <= code_nxt;
            ack_sel  <= ack_sel_nxt;
            // A new edge in the same cycle as its acknowledge keeps the bit set.
            pending  <= (pending & ~irq_ack) | (irq_req & ~irq_prev);
        end
    end

    always_comb begin
        exc_take    = (state == TAKE);
        irq_ack     = (state == TAKE) ? ack_sel : '0;
        irq_pending = pending;
        in_handler  = (state == HANDLER) || (state == FAULT);
        fault       = (state == FAULT);
        unique case (state)
            TAKE, HANDLER: estatus = code;
            FAULT:         estatus = CODE_FAULT;
            default:       estatus = CODE_NONE;
        endcase
    end

`ifdef EXC_SEQ_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exc_count <= '0;
        end else if (exc_take && (exc_count != 16'hFFFF)) begin
            exc_count <= exc_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_exc_seq.sv
// Scoreboard bench for exc_seq: expected take {estatus, irq_ack} pairs are queued by the
// stimulus and popped by a monitor on each exc_take; define EXC_SEQ_CNT_EN to check exc_count.
module tb_exc_seq;

    localparam int N_IRQ     = 4;
    localparam int ESTATUS_W = 4;

    logic                 clk;
    logic                 reset;
    logic                 not_an_instr;
    logic                 eret;
    logic                 irq_en;
    logic [N_IRQ-1:0]     irq_req;
    logic                 exc_take;
    logic [ESTATUS_W-1:0] estatus;
    logic [N_IRQ-1:0]     irq_ack;
    logic [N_IRQ-1:0]     irq_pending;
    logic                 in_handler;
    logic                 fault;
`ifdef EXC_SEQ_CNT_EN
    logic [15:0]          exc_count;
`endif

    typedef struct packed {
        logic [ESTATUS_W-1:0] code;
        logic [N_IRQ-1:0]     ack;
    } take_t;

    take_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    exc_seq #(.N_IRQ(N_IRQ), .ESTATUS_W(ESTATUS_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .not_an_instr(not_an_instr),
        .eret        (eret),
        .irq_en      (irq_en),
        .irq_req     (irq_req),
        .exc_take    (exc_take),
        .estatus     (estatus),
        .irq_ack     (irq_ack),
        .irq_pending (irq_pending),
        .in_handler  (in_handler),
        .fault       (fault)
`ifdef EXC_SEQ_CNT_EN
        ,
        .exc_count   (exc_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Exit the handler with a one-cycle eret.
    task automatic do_eret();
        eret = 1'b1;
        tick();
        eret = 1'b0;
    endtask

    // Monitor: every take must match the oldest queued expectation.
    always @(negedge clk) begin
        if (exc_take === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_take", {28'd0, estatus}, 32'hDEAD);
            end else begin
                take_t e;
                e = exp_q.pop_front();
                check("take_estatus", 32'(estatus), 32'(e.code));
                check("take_irq_ack", 32'(irq_ack), 32'(e.ack));
            end
        end
    end

    initial begin
        reset        = 1'b0;
        not_an_instr = 1'b0;
        eret         = 1'b0;
        irq_en       = 1'b0;
        irq_req      = '0;
        tick(2);
        check("rst_exc_take", 32'(exc_take), 0);
        check("rst_estatus", 32'(estatus), 0);
        check("rst_pending", 32'(irq_pending), 0);
        check("rst_in_handler", 32'(in_handler), 0);
        check("rst_fault", 32'(fault), 0);
        reset = 1'b1;
        tick();

        // Invalid opcode in RUN.
        exp_q.push_back('{code: 4'h2, ack: 4'b0000});
        not_an_instr = 1'b1;
        tick();
        not_an_instr = 1'b0;
        check("inv_take", 32'(exc_take), 1);
        tick();
        check("inv_in_handler", 32'(in_handler), 1);
        check("inv_handler_estatus", 32'(estatus), 2);
        check("inv_no_take", 32'(exc_take), 0);
        do_eret();
        check("inv_eret_estatus", 32'(estatus), 0);
        check("inv_eret_in_handler", 32'(in_handler), 0);

        // Priority: two IRQs rising together.
        irq_en  = 1'b1;
        irq_req = 4'b0110;
        tick();
        check("prio_pending", 32'(irq_pending), 32'b0110);
        exp_q.push_back('{code: 4'h9, ack: 4'b0010});
        tick();
        check("prio_take1", 32'(exc_take), 1);
        tick();
        check("prio_pending_after1", 32'(irq_pending), 32'b0100);
        exp_q.push_back('{code: 4'hA, ack: 4'b0100});
        do_eret();
        tick();
        check("prio_take2", 32'(exc_take), 1);
        tick();
        check("prio_pending_after2", 32'(irq_pending), 0);
        do_eret();
        irq_req = '0;
        tick();

        // Masking, then no nesting.
        irq_en  = 1'b0;
        irq_req = 4'b0001;
        tick(3);
        check("mask_pending", 32'(irq_pending), 32'b0001);
        check("mask_no_take", 32'(exc_take), 0);
        exp_q.push_back('{code: 4'h8, ack: 4'b0001});
        irq_en = 1'b1;
        tick();
        check("unmask_take", 32'(exc_take), 1);
        tick();
        irq_req = 4'b1001;
        tick();
        check("nest_pending", 32'(irq_pending), 32'b1000);
        tick();
        check("nest_no_take", 32'(exc_take), 0);
        check("nest_in_handler", 32'(in_handler), 1);
        exp_q.push_back('{code: 4'hB, ack: 4'b1000});
        do_eret();
        tick();
        check("nest_take_after_eret", 32'(exc_take), 1);
        tick();
        do_eret();
        irq_req = '0;
        tick();

        // Collision: invalid opcode beats a pending IRQ.
        irq_en  = 1'b0;
        irq_req = 4'b0001;
        tick();
        exp_q.push_back('{code: 4'h2, ack: 4'b0000});
        not_an_instr = 1'b1;
        irq_en       = 1'b1;
        tick();
        not_an_instr = 1'b0;
        check("coll_pending_take", 32'(irq_pending), 32'b0001);
        tick();
        check("coll_pending_handler", 32'(irq_pending), 32'b0001);
        exp_q.push_back('{code: 4'h8, ack: 4'b0001});
        do_eret();
        tick(2);
        do_eret();
        irq_req = '0;
        tick();

        // Double fault: not_an_instr together with eret in HANDLER.
        exp_q.push_back('{code: 4'h2, ack: 4'b0000});
        not_an_instr = 1'b1;
        tick();
        not_an_instr = 1'b0;
        tick();
        not_an_instr = 1'b1;
        eret         = 1'b1;
        tick();
        not_an_instr = 1'b0;
        eret         = 1'b0;
        check("df_fault", 32'(fault), 1);
        check("df_estatus", 32'(estatus), 32'hF);
        check("df_in_handler", 32'(in_handler), 1);
        eret    = 1'b1;
        irq_req = 4'b0010;
        tick(3);
        check("df_sticky_fault", 32'(fault), 1);
        check("df_sticky_estatus", 32'(estatus), 32'hF);
        check("df_no_take", 32'(exc_take), 0);
        eret    = 1'b0;
        irq_req = '0;
        reset   = 1'b0;
        #1;
        check("df_reset_fault", 32'(fault), 0);
        check("df_reset_estatus", 32'(estatus), 0);
        check("df_reset_pending", 32'(irq_pending), 0);
        tick();
        reset = 1'b1;
        tick();

        // Reset in the middle of a take.
        irq_en  = 1'b0;
        irq_req = 4'b0100;
        tick();
        exp_q.push_back('{code: 4'h2, ack: 4'b0000});
        not_an_instr = 1'b1;
        tick();
        not_an_instr = 1'b0;
        check("rtake_take_high", 32'(exc_take), 1);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rtake_exc_take", 32'(exc_take), 0);
        check("rtake_irq_ack", 32'(irq_ack), 0);
        check("rtake_pending", 32'(irq_pending), 0);
        check("rtake_estatus", 32'(estatus), 0);
        check("rtake_in_handler", 32'(in_handler), 0);
        irq_req = '0;
        tick();
        reset = 1'b1;
        tick();

`ifdef EXC_SEQ_CNT_EN
        check("cnt_after_reset", 32'(exc_count), 0);
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back('{code: 4'h2, ack: 4'b0000});
            not_an_instr = 1'b1;
            tick();
            not_an_instr = 1'b0;
            tick();
            do_eret();
        end
        check("cnt_three", 32'(exc_count), 3);
        reset = 1'b0;
        #1;
        check("cnt_reset", 32'(exc_count), 0);
        tick();
        reset = 1'b1;
        tick();
`endif

        tick(2);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
